// File: rtl/bpb_table_pkg.sv
// Shared types and defaults for the tagged branch prediction buffer.
// Holds the prediction result struct, the default table size and the counter encoding.
package bpb_table_pkg;

  localparam int unsigned BPB_ENTRY_WIDTH = 6;

  typedef struct packed {
    logic        taken;
    logic [31:0] destpc;
  } bpb_result_t;

  // 2-bit hysteresis counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bpb_state_t;

endpackage

// File: rtl/bpb_table_if.sv
// Front-end <-> predictor bundle: two fetch-slot lookups plus one commit update.
// The master modport is the pipeline side; the slave modport is the table.
interface bpb_table_if;
  import bpb_table_pkg::*;

  logic                   stall;
  logic [1:0][31:0]       pc_predict;
  logic [1:0]             hit_predict;
  bpb_result_t [1:0]      destpc_predict;
  logic                   wen;
  logic [31:0]            pc_commit;
  logic                   taken_commit;
  logic [31:0]            destpc_commit;

  modport master (
    output stall,
    output pc_predict,
    input  hit_predict,
    input  destpc_predict,
    output wen,
    output pc_commit,
    output taken_commit,
    output destpc_commit
  );

  modport slave (
    input  stall,
    input  pc_predict,
    output hit_predict,
    output destpc_predict,
    input  wen,
    input  pc_commit,
    input  taken_commit,
    input  destpc_commit
  );

endinterface

// File: rtl/bpb_counter2.sv
// Combinational next-state function of the 2-bit hysteresis counter.
// Weak-taken and weak-not-taken both collapse to strong states on a single outcome.
module bpb_counter2
  import bpb_table_pkg::*;
(
  input  bpb_state_t state,
  input  logic       taken,
  output bpb_state_t state_next
);

  always_comb begin
    state_next = SNT;
    unique case (state)
      SNT:     state_next = taken ? WNT : SNT;
      WNT:     state_next = taken ? ST  : SNT;
      WT:      state_next = taken ? ST  : SNT;
      ST:      state_next = taken ? ST  : WT;
      default: state_next = SNT;
    endcase
  end

endmodule

// File: rtl/bpb_table.sv
// Direct-mapped, tagged BHT+BTB: two combinational lookups and one commit update per cycle.
// Only the valid vector is reset; tag, counter and target arrays are qualified by it.
module bpb_table
  import bpb_table_pkg::*;
#(
  parameter int unsigned ENTRY_WIDTH = BPB_ENTRY_WIDTH,
  parameter bpb_state_t  INIT_STATE  = WT
) (
  input logic        clk,
  input logic        reset,
  bpb_table_if.slave bus
);

  localparam int unsigned TAG_WIDTH = 30 - ENTRY_WIDTH;
  localparam int unsigned ENTRIES   = 1 << ENTRY_WIDTH;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  bpb_state_t           state_q  [ENTRIES];
  logic [31:0]          target_q [ENTRIES];

  // Commit side
  logic [ENTRY_WIDTH-1:0] commit_idx;
  logic [TAG_WIDTH-1:0]   commit_tag;
  logic                   commit_hit;
  logic                   update_en;
  bpb_state_t             commit_state;
  bpb_state_t             commit_state_next;

  assign commit_idx   = bus.pc_commit[ENTRY_WIDTH+1:2];
  assign commit_tag   = bus.pc_commit[31:ENTRY_WIDTH+2];
  assign commit_hit   = valid_q[commit_idx] && (tag_q[commit_idx] == commit_tag);
  assign update_en    = reset && bus.wen && !bus.stall;
  // A miss allocates from INIT_STATE and applies the outcome in the same update.
  assign commit_state = commit_hit ? state_q[commit_idx] : INIT_STATE;

  bpb_counter2 u_counter (
    .state      (commit_state),
    .taken      (bus.taken_commit),
    .state_next (commit_state_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (update_en) begin
      valid_q[commit_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (update_en) begin
      tag_q[commit_idx]   <= commit_tag;
      state_q[commit_idx] <= commit_state_next;
      // A not-taken hit keeps the old target so a later taken prediction stays useful.
      if (!commit_hit || bus.taken_commit) begin
        target_q[commit_idx] <= bus.destpc_commit;
      end
    end
  end

  // Prediction side: reads see pre-update contents (read-before-write).
  logic [1:0]        hit_vec;
  bpb_result_t [1:0] result_vec;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    logic [ENTRY_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   hit;

    assign idx = bus.pc_predict[s][ENTRY_WIDTH+1:2];
    assign tag = bus.pc_predict[s][31:ENTRY_WIDTH+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    assign hit_vec[s]           = hit;
    assign result_vec[s].taken  = hit && state_q[idx][1];
    assign result_vec[s].destpc = hit ? target_q[idx] : 32'h0;
  end

  assign bus.hit_predict    = hit_vec;
  assign bus.destpc_predict = result_vec;

  // Word-aligned PCs: the low two bits never select anything.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_predict[1][1:0], bus.pc_predict[0][1:0], bus.pc_commit[1:0]};

endmodule

// File: tb/tb_bpb_table.sv
// Directed scoreboard bench for bpb_table: probes push expectations, a negedge monitor pops them.
module tb_bpb_table;
  import bpb_table_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bpb_table_if bus ();

  bpb_table #(
    .ENTRY_WIDTH (6),
    .INIT_STATE  (WT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  hit;
    logic [1:0]  taken;
    logic [31:0] dest1;
    logic [31:0] dest0;
  } exp_t;

  exp_t sbq[$];
  logic probe;
  int   vectors     = 0;
  int   miscompares = 0;

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [1:0] got_taken;
    if (probe) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: got a probe with no expectation queued");
      end else begin
        e         = sbq.pop_front();
        got_taken = {bus.destpc_predict[1].taken, bus.destpc_predict[0].taken};
        if (bus.hit_predict !== e.hit || got_taken !== e.taken ||
            bus.destpc_predict[1].destpc !== e.dest1 ||
            bus.destpc_predict[0].destpc !== e.dest0) begin
          miscompares++;
          $display("FAIL %s: got hit=%b taken=%b dest1=%h dest0=%h, want hit=%b taken=%b dest1=%h dest0=%h",
                   e.name, bus.hit_predict, got_taken, bus.destpc_predict[1].destpc,
                   bus.destpc_predict[0].destpc, e.hit, e.taken, e.dest1, e.dest0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    probe            = 1'b0;
    bus.wen          = 1'b0;
    bus.stall        = 1'b0;
    bus.taken_commit = 1'b0;
    reset            = 1'b1;
  endtask

  task automatic lookup(input string name, input logic [31:0] p1, input logic [31:0] p0,
                        input logic [1:0] h, input logic [1:0] t,
                        input logic [31:0] d1, input logic [31:0] d0);
    exp_t e;
    bus.pc_predict = {p1, p0};
    probe          = 1'b1;
    e.name  = name;
    e.hit   = h;
    e.taken = t;
    e.dest1 = d1;
    e.dest0 = d0;
    sbq.push_back(e);
  endtask

  task automatic commit(input logic [31:0] pc, input logic t, input logic [31:0] d);
    bus.wen           = 1'b1;
    bus.pc_commit     = pc;
    bus.taken_commit  = t;
    bus.destpc_commit = d;
  endtask

  initial begin
    reset             = 1'b0;
    probe             = 1'b0;
    bus.stall         = 1'b0;
    bus.wen           = 1'b0;
    bus.pc_predict    = '0;
    bus.pc_commit     = '0;
    bus.taken_commit  = 1'b0;
    bus.destpc_commit = '0;
    tick();

    lookup("reset_lookup", 32'hBFC00010, 32'hBFC00014, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();

    // Allocate taken: INIT 10 + T -> 11
    commit(32'hBFC00100, 1'b1, 32'hBFC00200);
    tick();
    lookup("alloc_taken_both_slots", 32'hBFC00100, 32'hBFC00100, 2'b11, 2'b11,
           32'hBFC00200, 32'hBFC00200);
    tick();

    // Hysteresis 11 -N-> 10 -N-> 00 -T-> 01 -T-> 11
    commit(32'hBFC00100, 1'b0, 32'h12345678);
    tick();
    lookup("hyst_st_to_wt", 32'hBFC00100, 32'hBFC00010, 2'b10, 2'b10, 32'hBFC00200, 32'h0);
    tick();
    commit(32'hBFC00100, 1'b0, 32'h12345678);
    tick();
    lookup("hyst_wt_to_snt", 32'hBFC00010, 32'hBFC00100, 2'b01, 2'b00, 32'h0, 32'hBFC00200);
    tick();
    commit(32'hBFC00100, 1'b1, 32'hBFC00300);
    tick();
    lookup("hyst_snt_to_wnt", 32'hBFC00100, 32'hBFC00100, 2'b11, 2'b00,
           32'hBFC00300, 32'hBFC00300);
    tick();
    commit(32'hBFC00100, 1'b1, 32'hBFC00300);
    tick();
    lookup("hyst_wnt_to_st", 32'hBFC00100, 32'hBFC00100, 2'b11, 2'b11,
           32'hBFC00300, 32'hBFC00300);
    tick();

    // Alias eviction at index 0
    commit(32'h00000100, 1'b1, 32'h00000500);
    tick();
    lookup("alias_first_resident", 32'h00000100, 32'h00001100, 2'b10, 2'b10,
           32'h00000500, 32'h0);
    tick();
    commit(32'h00001100, 1'b0, 32'h00000900);
    tick();
    lookup("alias_evicted", 32'h00000100, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000900);
    tick();

    // Stall blocks updates, both on hit and on a would-be allocation
    bus.stall = 1'b1;
    commit(32'h00001100, 1'b1, 32'hAAAA0000);
    lookup("stall_same_cycle", 32'h00000200, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000900);
    tick();
    bus.stall = 1'b1;
    commit(32'h00000200, 1'b1, 32'hBBBB0000);
    lookup("stall_unchanged", 32'h00000200, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000900);
    tick();
    lookup("stall_no_alloc", 32'h00000200, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000900);
    tick();

    // Read-before-write: commit T on state 00 while slot 0 looks up the same PC
    commit(32'h00001100, 1'b1, 32'h00000A00);
    lookup("bypass_pre_update", 32'h00000200, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000900);
    tick();
    lookup("bypass_post_update", 32'h00000200, 32'h00001100, 2'b01, 2'b00, 32'h0, 32'h00000A00);
    tick();

    // Populate 4 entries, then reset together with wen
    commit(32'h00000010, 1'b1, 32'h00001000);
    tick();
    commit(32'h00000020, 1'b1, 32'h00002000);
    tick();
    commit(32'h00000030, 1'b0, 32'h00003000);
    tick();
    commit(32'h00000040, 1'b1, 32'h00004000);
    tick();
    lookup("populated_a", 32'h00000010, 32'h00000020, 2'b11, 2'b11, 32'h00001000, 32'h00002000);
    tick();
    lookup("populated_b", 32'h00000030, 32'h00000040, 2'b11, 2'b01, 32'h00003000, 32'h00004000);
    tick();
    reset = 1'b0;
    commit(32'h00000050, 1'b1, 32'h00005000);
    tick();
    lookup("post_reset_a", 32'h00000010, 32'h00000020, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    lookup("post_reset_b", 32'h00000030, 32'h00000040, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    lookup("post_reset_wen", 32'h00000050, 32'h00001100, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    tick();

    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
